// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating tie-break; otherwise data always wins a tie.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic rr_last,
  output logic winner_d
);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the requester that did not win last time is served.
  always_comb begin
    if (i_req && d_req) begin
      winner_d = (rr_last == REQ_I) ? REQ_D : REQ_I;
    end else begin
      winner_d = d_req ? REQ_D : REQ_I;
    end
  end
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
  assign winner_d       = d_req ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto the single-port unified memory.
// Optional round-robin tie-break via ARB_ROUND_ROBIN_EN (see arb_pick).
//
// Handshake: each requester holds req high until it sees its ack; ack is a
// one-cycle pulse and rdata stays valid from ack until the next load/fetch
// for that requester. Requests are only sampled in IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_d,
  output logic [1:0]        state_o
);

  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

  arb_state_t           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic                 owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]    i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
  logic                 rr_last;
  logic                 winner_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= REQ_I;
    end else if (state_q == IDLE && (i_req || d_req)) begin
      rr_last_q <= winner_d;
    end
  end
  assign rr_last = rr_last_q;
`else
  assign rr_last = REQ_I;
`endif

  arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .rr_last  (rr_last),
    .winner_d (winner_d)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_wr_d    = 1'b0;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d     = winner_d;
          busy_d      = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = ACCESS;
          if (winner_d == REQ_D) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            we_d        = d_we;
          end else begin
            mem_addr_d  = i_addr;
            we_d        = 1'b0;
          end
          // Strobe is registered, so it is high for exactly the first ACCESS cycle.
          mem_wr_d = (winner_d == REQ_D) && d_we;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == REQ_D) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      owner_q     <= REQ_I;
      busy_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_wr_q    <= mem_wr_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign grant_d   = owner_q;
  assign state_o   = state_q;

endmodule
